// File: rtl/cache_init_seq.sv
// Cache valid/tag array init walker: clears every set through the SRAM arbiter.
// Optional CACHE_INIT_DATA_CLR_EN also walks and clears every data-array beat.
module cache_init_seq #(
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned DATA_BEATS = 2,
    localparam int unsigned AW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int unsigned BW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                init_i,
    input  logic                rst_uarch_ni,
    output logic                busy_o,
    output logic                done_o,
    output logic                req_o,
    input  logic                gnt_i,
    output logic [AW-1:0]       addr_o,
    output logic [BW-1:0]       beat_o,
    output logic [NUM_WAYS-1:0] way_en_o,
    output logic                tag_we_o,
    output logic                data_we_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] WALK = 2'd2;

    localparam logic [AW-1:0] LAST_SET = AW'(NUM_SETS - 1);
`ifdef CACHE_INIT_DATA_CLR_EN
    localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_BEATS - 1);
`else
    // Without data clearing every set is a single beat.
    localparam logic [BW-1:0] LAST_BEAT = '0;
`endif

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          done_q, done_d;
    logic          last_beat;

    assign last_beat = (addr_q == LAST_SET) && (beat_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_i) begin
                    state_d = rst_uarch_ni ? WALK : ARM;
                    addr_d  = '0;
                    beat_d  = '0;
                end
            end
            ARM: begin
                addr_d = '0;
                beat_d = '0;
                if (rst_uarch_ni) begin
                    state_d = WALK;
                end
            end
            WALK: begin
                // Micro-reset beats restart; restart discards any grant.
                if (!rst_uarch_ni) begin
                    state_d = ARM;
                    addr_d  = '0;
                    beat_d  = '0;
                end else if (init_i) begin
                    addr_d = '0;
                    beat_d = '0;
                end else if (gnt_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        beat_d  = '0;
                    end else if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        addr_d = addr_q + AW'(1);
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ARM;
                addr_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARM;
            addr_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign req_o    = (state_q == WALK) && rst_uarch_ni;
    assign addr_o   = addr_q;
    assign way_en_o = {NUM_WAYS{req_o}};

`ifdef CACHE_INIT_DATA_CLR_EN
    assign beat_o    = beat_q;
    assign data_we_o = req_o;
`else
    assign beat_o    = '0;
    assign data_we_o = 1'b0;
`endif

    assign tag_we_o = req_o && (beat_o == '0);

endmodule
